// File: rtl/obi_sram_responder.sv
// OBI responder backed by word-addressed SRAM, with programmable grant latency,
// fixed response latency and an outstanding cap. `OBI_SRAM_RESP_ERR_EN adds err_o.
module obi_sram_responder #(
  parameter int NUM_WORDS       = 1024,
  parameter int GNT_LAT         = 0,
  parameter int RVALID_LAT      = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o
`ifdef OBI_SRAM_RESP_ERR_EN
  ,
  output logic        err_o
`endif
);

  localparam int AW     = $clog2(NUM_WORDS);
  localparam int STAGES = RVALID_LAT - 1;
  localparam int OW     = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GRANT} gst_e;

  logic [31:0]          mem [NUM_WORDS];
  logic [AW-1:0]        idx;
  logic                 acc;
  logic                 oor;
  logic                 unused_addr;
  logic [OW-1:0]        outst, outst_nxt;
  logic [STAGES:0]      vld_pipe;
  logic [STAGES:0][31:0] rdata_pipe;
  logic [31:0]          rd_new;

  assign idx = addr_i[2 +: AW];
  assign acc = req_i & gnt_o;

`ifdef OBI_SRAM_RESP_ERR_EN
  logic [STAGES:0] err_pipe;
  assign oor         = addr_i >= 32'(NUM_WORDS * 4);
  assign unused_addr = ^addr_i[1:0];
  assign err_o       = err_pipe[STAGES];
`else
  assign oor         = 1'b0;
  assign unused_addr = ^{addr_i[1:0], addr_i[31:2+AW]};
`endif

  assign outst_nxt = outst + OW'(acc) - OW'(rvalid_o);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) outst <= '0;
    else       outst <= outst_nxt;
  end

  generate
    if (GNT_LAT == 0) begin : g_comb
      assign gnt_o = req_i & (outst < OW'(MAX_OUTSTANDING));
    end else begin : g_fsm
      localparam int CW = $clog2(GNT_LAT + 1);
      gst_e          st, st_nxt;
      logic [CW-1:0] cnt, cnt_nxt;
      logic          nxt_ok;

      // gnt_o is registered, so the cap is judged on next cycle's count
      assign nxt_ok = outst_nxt < OW'(MAX_OUTSTANDING);

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          st  <= S_IDLE;
          cnt <= '0;
        end else begin
          st  <= st_nxt;
          cnt <= cnt_nxt;
        end
      end

      // The counter reaches 0 on the edge that enters GRANT, so gnt rises
      // exactly GNT_LAT cycles after the request is first seen.
      always_comb begin
        st_nxt  = st;
        cnt_nxt = cnt;
        case (st)
          S_IDLE, S_GRANT: begin
            st_nxt = S_IDLE;
            if (req_i) begin
              if (GNT_LAT == 1 && nxt_ok) st_nxt = S_GRANT;
              else begin
                st_nxt  = S_WAIT;
                cnt_nxt = CW'(GNT_LAT - 1);
              end
            end
          end
          S_WAIT: begin
            if (!req_i) st_nxt = S_IDLE;
            else if (cnt <= CW'(1) && nxt_ok) begin
              st_nxt  = S_GRANT;
              cnt_nxt = '0;
            end else if (cnt != '0) cnt_nxt = cnt - CW'(1);
          end
          default: st_nxt = S_IDLE;
        endcase
      end

      assign gnt_o = (st == S_GRANT);
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (acc && we_i && !oor)
      for (int b = 0; b < 4; b++)
        if (be_i[b]) mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
  end

  assign rd_new = (acc && !we_i && !oor) ? mem[idx] : 32'h0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_pipe   <= '0;
      rdata_pipe <= '0;
`ifdef OBI_SRAM_RESP_ERR_EN
      err_pipe   <= '0;
`endif
    end else begin
      vld_pipe[0]   <= acc;
      rdata_pipe[0] <= rd_new;
`ifdef OBI_SRAM_RESP_ERR_EN
      err_pipe[0]   <= acc & oor;
`endif
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i]   <= vld_pipe[i-1];
        rdata_pipe[i] <= rdata_pipe[i-1];
`ifdef OBI_SRAM_RESP_ERR_EN
        err_pipe[i]   <= err_pipe[i-1];
`endif
      end
    end
  end

  assign rvalid_o = vld_pipe[STAGES];
  assign rdata_o  = rdata_pipe[STAGES];

endmodule

// File: tb/tb_obi_sram_responder.sv
// Scoreboard bench: three responder configs (A: lat0/rv1/cap1, B: lat3/rv2/cap2, C: lat0/rv4/cap2).
module tb_obi_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req [3];
  logic        we [3];
  logic [3:0]  be [3];
  logic [31:0] addr [3];
  logic [31:0] wdata [3];
  logic        gnt [3];
  logic        rvalid [3];
  logic [31:0] rdata [3];
`ifdef OBI_SRAM_RESP_ERR_EN
  logic        err [3];
`endif

  int cyc = 0;
  int tot = 0;
  int bad = 0;

  typedef struct {
    int          k;
    logic [31:0] d;
    logic        e;
    int          acc;
    int          lat;
  } ent_t;

  ent_t        sb [$];
  logic [31:0] mdl [3][1024];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  obi_sram_responder #(.NUM_WORDS(1024), .GNT_LAT(0), .RVALID_LAT(1), .MAX_OUTSTANDING(1)) u_a (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]), .be_i(be[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0])
`ifdef OBI_SRAM_RESP_ERR_EN
    , .err_o(err[0])
`endif
  );

  obi_sram_responder #(.NUM_WORDS(1024), .GNT_LAT(3), .RVALID_LAT(2), .MAX_OUTSTANDING(2)) u_b (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]), .be_i(be[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1])
`ifdef OBI_SRAM_RESP_ERR_EN
    , .err_o(err[1])
`endif
  );

  obi_sram_responder #(.NUM_WORDS(1024), .GNT_LAT(0), .RVALID_LAT(4), .MAX_OUTSTANDING(2)) u_c (
    .clk_i(clk), .rst_i(rst), .req_i(req[2]), .we_i(we[2]), .be_i(be[2]), .addr_i(addr[2]),
    .wdata_i(wdata[2]), .gnt_o(gnt[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2])
`ifdef OBI_SRAM_RESP_ERR_EN
    , .err_o(err[2])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tot++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    req[k] = 1'b0;
  endtask

  // Drives one request and leaves req high; the caller idles or issues the next.
  task automatic issue(input int k, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d, output int gc);
    ent_t        e;
    logic [9:0]  wi;
    logic        er;
    req[k] = 1'b1; we[k] = w; be[k] = b; addr[k] = a; wdata[k] = d;
    gc = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (gnt[k]) begin
        gc = cyc;
        break;
      end
      step();
    end
    if (gc < 0) chk($sformatf("gnt_timeout%0d", k), 32'd0, 32'd1);
    else begin
      wi = a[11:2];
      er = 1'b0;
`ifdef OBI_SRAM_RESP_ERR_EN
      er = (a >= 32'h1000);
`endif
      if (w && !er)
        for (int i = 0; i < 4; i++)
          if (b[i]) mdl[k][wi][8*i +: 8] = d[8*i +: 8];
      e.k   = k;
      e.d   = (w || er) ? 32'h0 : mdl[k][wi];
      e.e   = er;
      e.acc = gc;
      e.lat = (k == 0) ? 1 : (k == 1) ? 2 : 4;
      sb.push_back(e);
      step();
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && sb.size() != 0; n++) step();
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        int j;
        j = -1;
        if (rvalid[k]) begin
          for (int i = 0; i < sb.size(); i++)
            if (j < 0 && sb[i].k == k) j = i;
          if (j < 0) chk($sformatf("unexp_rvalid%0d", k), 32'd1, 32'd0);
          else begin
            chk($sformatf("rdata%0d", k), rdata[k], sb[j].d);
            chk($sformatf("rvalid_lat%0d", k), 32'(cyc - sb[j].acc), 32'(sb[j].lat));
`ifdef OBI_SRAM_RESP_ERR_EN
            chk($sformatf("err%0d", k), 32'(err[k]), 32'(sb[j].e));
`endif
            sb.delete(j);
          end
        end else begin
          chk($sformatf("idle_rdata%0d", k), rdata[k], 32'h0);
`ifdef OBI_SRAM_RESP_ERR_EN
          chk($sformatf("idle_err%0d", k), 32'(err[k]), 32'd0);
`endif
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, g, g1, g2, g3;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; be[k] = 4'h0; addr[k] = 32'h0; wdata[k] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_gnt%0d", k), 32'(gnt[k]), 32'd0);
      chk($sformatf("rst_rvalid%0d", k), 32'(rvalid[k]), 32'd0);
      chk($sformatf("rst_rdata%0d", k), rdata[k], 32'h0);
    end
    step();

    // A: same-cycle grant, full then partial write
    t = cyc; issue(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, g); chk("a_wr_gnt_cycle", 32'(g - t), 32'd0);
    idle(0); step();
    t = cyc; issue(0, 1'b0, 4'hF, 32'h10, 32'h0, g); chk("a_rd_gnt_cycle", 32'(g - t), 32'd0);
    idle(0); step();
    issue(0, 1'b1, 4'b0010, 32'h10, 32'h0000AA00, g); idle(0); step();
    issue(0, 1'b0, 4'hF, 32'h10, 32'h0, g); idle(0); step();
    for (int i = 0; i < 4; i++) issue(0, 1'b1, 4'hF, 32'h100 + 32'(i * 4), $urandom(), g);
    for (int i = 0; i < 4; i++) issue(0, 1'b0, 4'hF, 32'h100 + 32'(i * 4), 32'h0, g);
    idle(0);
    // out-of-range write: error response, or wraps onto word 0
    issue(0, 1'b1, 4'hF, 32'h0, 32'h12345678, g);
    issue(0, 1'b1, 4'hF, 32'h1000, 32'hCAFEF00D, g);
    issue(0, 1'b0, 4'hF, 32'h0, 32'h0, g);
    idle(0);
    drain();

    // B: grant latency 3, back-to-back cost, dropped request
    t = cyc; issue(1, 1'b1, 4'hF, 32'h40, 32'hA5A55A5A, g1); chk("b_gnt_lat", 32'(g1 - t), 32'd3);
    issue(1, 1'b0, 4'hF, 32'h40, 32'h0, g2); chk("b_b2b_gap", 32'(g2 - g1), 32'd3);
    idle(1); step();
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h40;
    @(negedge clk); chk("b_drop_gnt", 32'(gnt[1]), 32'd0);
    step(); req[1] = 1'b0;
    repeat (6) begin
      @(negedge clk); chk("b_drop_gnt", 32'(gnt[1]), 32'd0);
      step();
    end
    t = cyc; issue(1, 1'b0, 4'hF, 32'h40, 32'h0, g); chk("b_gnt_lat_after_drop", 32'(g - t), 32'd3);
    idle(1);
    drain();

    // C: outstanding cap with rvalid latency 4
    for (int i = 0; i < 3; i++) issue(2, 1'b1, 4'hF, 32'h200 + 32'(i * 4), $urandom(), g);
    idle(2);
    drain();
    issue(2, 1'b0, 4'hF, 32'h200, 32'h0, g1);
    issue(2, 1'b0, 4'hF, 32'h204, 32'h0, g2);
    issue(2, 1'b0, 4'hF, 32'h208, 32'h0, g3);
    idle(2);
    chk("c_second_gnt", 32'(g2 - g1), 32'd1);
    chk("c_third_gnt", 32'(g3 - g1), 32'd5);
    drain();

    // reset with a response in flight: it must vanish, SRAM must survive
    issue(2, 1'b0, 4'hF, 32'h200, 32'h0, g);
    idle(2); step();
    rst = 1'b1;
    for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].k == 2) sb.delete(i);
    step(); step();
    rst = 1'b0;
    repeat (8) step();
    issue(0, 1'b0, 4'hF, 32'h10, 32'h0, g); idle(0);
    t = cyc; issue(2, 1'b0, 4'hF, 32'h204, 32'h0, g); chk("c_gnt_after_rst", 32'(g - t), 32'd0);
    idle(2);
    drain();

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
